// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants, fetch FSM encoding and fetch payload type
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSN = {25'b0, OP_IMM};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, ins} entries with priority flush
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    assign empty  = r_cnt == '0;
    assign full   = r_cnt == CNT_W'(DEPTH);
    assign count  = r_cnt;
    assign dout   = r_mem[r_rd];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Payload storage; entries are only read while counted as valid, so no reset
    always_ff @(posedge clk) begin
        if (w_push && !flush)
            r_mem[r_wr] <= din;
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= w_push ? ((r_wr == LAST) ? '0 : r_wr + 1'b1) : r_wr;
            r_rd  <= w_pop ? ((r_rd == LAST) ? '0 : r_rd + 1'b1) : r_rd;
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage - PC, imem req/gnt/rvalid, instruction buffer, redirect flush
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2,
    parameter int              CNT_W      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins,
    output logic [XLEN-1:0] ins_pc,
    input  logic            ins_ready
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_ins_pc;
    logic [CNT_W-1:0] r_out;
    logic [CNT_W-1:0] r_disc;
    logic [CNT_W-1:0] w_out_next;
    logic [CNT_W-1:0] w_disc_next;
    logic [CNT_W-1:0] w_tag_cnt;
    logic [CNT_W-1:0] w_ibuf_cnt;
    logic [CNT_W:0]   w_occ;
    logic             w_fire;
    logic             w_keep;
    logic             w_pop;
    logic             w_tag_full;
    logic             w_tag_empty;
    logic             w_ibuf_full;
    logic             w_ibuf_empty;
    fetch_entry_t     w_tag_head;
    fetch_entry_t     w_ibuf_head;
    logic             w_unused;

    assign w_fire     = imem_req && imem_gnt;
    assign w_keep     = imem_rvalid && (r_disc == '0);
    assign w_pop      = ins_valid && ins_ready;
    assign w_out_next = r_out + CNT_W'(w_fire) - CNT_W'(imem_rvalid);
    assign w_occ      = {1'b0, w_ibuf_cnt} + {1'b0, r_out};
    assign imem_addr  = r_pc;
    assign ins_valid  = !w_ibuf_empty;
    assign ins        = w_ibuf_empty ? NOP_INSN : w_ibuf_head.ins;
    assign ins_pc     = w_ibuf_empty ? r_ins_pc : w_ibuf_head.pc;
    assign w_unused   = ^{redirect_pc[1:0], w_tag_head.ins, w_tag_cnt, w_tag_full,
                          w_tag_empty, w_ibuf_full};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next state, request issue and discard bookkeeping; on redirect every
    // request still in flight after this cycle is stale
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        w_disc_next  = redirect_valid ? w_out_next
                                      : r_disc - CNT_W'(imem_rvalid && (r_disc != '0));
        case (r_state)
            ST_IDLE:  w_state_next = ST_RUN;
            ST_RUN: begin
                imem_req     = !redirect_valid && (w_occ < DEPTH_C);
                w_state_next = (w_disc_next != '0) ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: w_state_next = (w_disc_next == '0) ? ST_RUN : ST_DRAIN;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // PC, outstanding/discard counters and last presented ins_pc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_out    <= '0;
            r_disc   <= '0;
            r_ins_pc <= '0;
        end else begin
            r_pc     <= redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00}
                      : w_fire ? pc_inc(r_pc) : r_pc;
            r_out    <= w_out_next;
            r_disc   <= w_disc_next;
            r_ins_pc <= ins_pc;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fire),
        .pop   (imem_rvalid),
        .flush (redirect_valid),
        .din   ('{pc: r_pc, ins: '0}),
        .dout  (w_tag_head),
        .count (w_tag_cnt),
        .full  (w_tag_full),
        .empty (w_tag_empty)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_ibuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_keep),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   ('{pc: w_tag_head.pc, ins: imem_rdata}),
        .dout  (w_ibuf_head),
        .count (w_ibuf_cnt),
        .full  (w_ibuf_full),
        .empty (w_ibuf_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with an in-order memory model
module tb_fetch_unit;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;

    int          n_chk;
    int          n_err;
    int          cyc;
    int          first_gnt;
    int          first_val;
    logic        rsp_en;
    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_ins[$];

    fetch_unit #(.RESET_PC(32'h100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_drive();
        imem_rvalid = rsp_en && (pend.size() > 0);
        imem_rdata  = imem_rvalid ? mem_fn(pend[0]) : 32'h0;
    endtask

    task automatic clear_logs();
        req_log.delete();
        del_pc.delete();
        del_ins.delete();
        cyc       = 0;
        first_gnt = -1;
        first_val = -1;
    endtask

    task automatic cycle();
        logic        fire;
        logic        rv;
        logic [31:0] a;
        @(negedge clk);
        fire = imem_req && imem_gnt;
        rv   = imem_rvalid;
        a    = imem_addr;
        if (fire) begin
            req_log.push_back(a);
            if (first_gnt < 0) first_gnt = cyc;
        end
        if (ins_valid && first_val < 0) first_val = cyc;
        if (ins_valid && ins_ready) begin
            del_pc.push_back(ins_pc);
            del_ins.push_back(ins);
        end
        @(posedge clk);
        #1;
        if (rv) void'(pend.pop_front());
        if (fire) pend.push_back(a);
        cyc++;
        mem_drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input logic ready, input logic en);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ins_ready      = ready;
        rsp_en         = en;
        pend.delete();
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic do_redirect(input string tag, input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        #1;
        chk(tag, 32'(imem_req), 32'h0);
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        imem_gnt = 1'b1;
        rst_n    = 1'b0;

        // basic streaming from RESET_PC with 1-cycle memory latency
        do_reset(1'b1, 1'b1);
        #1;
        chk("t1 rst req", 32'(imem_req), 32'h0);
        chk("t1 rst addr", imem_addr, 32'h100);
        chk("t1 rst valid", 32'(ins_valid), 32'h0);
        chk("t1 rst ins", ins, 32'h0000_0013);
        chk("t1 rst ins_pc", ins_pc, 32'h0);
        run(12);
        chk("t1 addr0", qat(req_log, 0), 32'h100);
        chk("t1 addr1", qat(req_log, 1), 32'h104);
        chk("t1 addr2", qat(req_log, 2), 32'h108);
        chk("t1 pc0", qat(del_pc, 0), 32'h100);
        chk("t1 pc1", qat(del_pc, 1), 32'h104);
        chk("t1 pc2", qat(del_pc, 2), 32'h108);
        chk("t1 ins0", qat(del_ins, 0), mem_fn(32'h100));
        chk("t1 ins2", qat(del_ins, 2), mem_fn(32'h108));
        chk("t1 latency", 32'(first_val - first_gnt), 32'd2);

        // decode stall: at most two grants, head held stable, then lossless resume
        do_reset(1'b0, 1'b1);
        run(10);
        chk("t2 ngnt", 32'(req_log.size()), 32'd2);
        chk("t2 req low", 32'(imem_req), 32'h0);
        chk("t2 valid", 32'(ins_valid), 32'h1);
        chk("t2 hold pc", ins_pc, 32'h100);
        chk("t2 hold ins", ins, mem_fn(32'h100));
        ins_ready = 1'b1;
        clear_logs();
        run(12);
        chk("t2 pc0", qat(del_pc, 0), 32'h100);
        chk("t2 pc1", qat(del_pc, 1), 32'h104);
        chk("t2 pc2", qat(del_pc, 2), 32'h108);
        chk("t2 pc3", qat(del_pc, 3), 32'h10C);
        chk("t2 ins3", qat(del_ins, 3), mem_fn(32'h10C));

        // redirect with two requests outstanding, responses arrive afterwards
        do_reset(1'b1, 1'b0);
        run(3);
        chk("t3 pre ngnt", 32'(req_log.size()), 32'd2);
        do_redirect("t3 redir req", 32'h203);
        rsp_en = 1'b1;
        mem_drive();
        #1;
        chk("t3 valid", 32'(ins_valid), 32'h0);
        chk("t3 drain req", 32'(imem_req), 32'h0);
        clear_logs();
        run(12);
        chk("t3 addr0", qat(req_log, 0), 32'h200);
        chk("t3 pc0", qat(del_pc, 0), 32'h200);
        chk("t3 ins0", qat(del_ins, 0), mem_fn(32'h200));
        chk("t3 pc1", qat(del_pc, 1), 32'h204);

        // redirect with gnt high and an older rvalid in the same cycle, two outstanding
        do_reset(1'b1, 1'b0);
        run(3);
        rsp_en = 1'b1;
        mem_drive();
        do_redirect("t4 redir req", 32'h400);
        clear_logs();
        run(12);
        chk("t4 addr0", qat(req_log, 0), 32'h400);
        chk("t4 pc0", qat(del_pc, 0), 32'h400);
        chk("t4 ins0", qat(del_ins, 0), mem_fn(32'h400));

        // redirect with one outstanding whose rvalid lands in the redirect cycle
        do_reset(1'b1, 1'b1);
        run(2);
        do_redirect("t4b redir req", 32'h500);
        clear_logs();
        run(12);
        chk("t4b addr0", qat(req_log, 0), 32'h500);
        chk("t4b pc0", qat(del_pc, 0), 32'h500);

        // PC wrap from the top of the address space
        do_reset(1'b1, 1'b1);
        run(1);
        do_redirect("t5 redir req", 32'hFFFF_FFFF);
        clear_logs();
        run(12);
        chk("t5 addr0", qat(req_log, 0), 32'hFFFF_FFFC);
        chk("t5 addr1", qat(req_log, 1), 32'h0);
        chk("t5 pc0", qat(del_pc, 0), 32'hFFFF_FFFC);
        chk("t5 pc1", qat(del_pc, 1), 32'h0);
        chk("t5 ins1", qat(del_ins, 1), mem_fn(32'h0));

        // asynchronous reset mid-stream with two requests outstanding
        do_reset(1'b1, 1'b1);
        run(5);
        rsp_en = 1'b0;
        mem_drive();
        run(1);
        chk("t6 pre ins_pc", ins_pc, 32'h104);
        chk("t6 pre addr", imem_addr, 32'h110);
        rst_n = 1'b0;
        #1;
        chk("t6 rst req", 32'(imem_req), 32'h0);
        chk("t6 rst addr", imem_addr, 32'h100);
        chk("t6 rst valid", 32'(ins_valid), 32'h0);
        chk("t6 rst ins", ins, 32'h0000_0013);
        chk("t6 rst ins_pc", ins_pc, 32'h0);
        do_reset(1'b1, 1'b1);
        run(12);
        chk("t6 addr0", qat(req_log, 0), 32'h100);
        chk("t6 pc0", qat(del_pc, 0), 32'h100);
        chk("t6 ins0", qat(del_ins, 0), mem_fn(32'h100));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
